// File: rtl/i2c_reg_sequencer_if.sv
// Bundle of request, byte-core and response signals for the I2C register sequencer.
// The master modport is the sequencer's view; slave is the environment's view.
interface i2c_reg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       core_ready;
  logic       core_write;
  logic [2:0] core_cmd;
  logic [7:0] core_data;
  logic       core_nack;
  logic       core_rx_ack;
  logic [7:0] core_rx_data;
  logic       rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  core_ready, core_rx_ack, core_rx_data,
    output req_ready, core_write, core_cmd, core_data, core_nack,
    output rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output core_ready, core_rx_ack, core_rx_data,
    input  req_ready, core_write, core_cmd, core_data, core_nack,
    input  rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into a START/WRITE/RESTART/READ/STOP command
// sequence for a byte-level I2C core, with NACK handling and a per-phase timeout.
module i2c_reg_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input logic                  clk,
  input logic                  rst_n,
  i2c_reg_sequencer_if.master  bus
);
  // Command codes shared with the byte-level core (i2c.vh)
  localparam logic [2:0] k_START_CMD   = 3'd1;
  localparam logic [2:0] k_RESTART_CMD = 3'd2;
  localparam logic [2:0] k_STOP_CMD    = 3'd3;
  localparam logic [2:0] k_READ_CMD    = 3'd4;
  localparam logic [2:0] k_WRITE_CMD   = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_step, w_step_next;
  logic [15:0] r_tmo, w_tmo_next, w_tmo_inc;
  logic        r_rw;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg, r_wdata;
  logic [1:0]  r_err, w_err_next;
  logic [7:0]  r_rdata, w_rdata_next;
  logic        w_accept, w_waiting, w_strobe;
  logic [2:0]  w_cmd, w_stop_step;
  logic [7:0]  w_data;
  logic        w_nack;

  // Command for the current step
  always_comb begin
    w_cmd  = k_STOP_CMD;
    w_data = 8'h00;
    w_nack = 1'b0;
    if (!r_rw) begin
      case (r_step)
        3'd0:    w_cmd = k_START_CMD;
        3'd1:    begin w_cmd = k_WRITE_CMD; w_data = {r_dev, 1'b0}; end
        3'd2:    begin w_cmd = k_WRITE_CMD; w_data = r_reg; end
        3'd3:    begin w_cmd = k_WRITE_CMD; w_data = r_wdata; end
        default: w_cmd = k_STOP_CMD;
      endcase
    end else begin
      case (r_step)
        3'd0:    w_cmd = k_START_CMD;
        3'd1:    begin w_cmd = k_WRITE_CMD; w_data = {r_dev, 1'b0}; end
        3'd2:    begin w_cmd = k_WRITE_CMD; w_data = r_reg; end
        3'd3:    w_cmd = k_RESTART_CMD;
        3'd4:    begin w_cmd = k_WRITE_CMD; w_data = {r_dev, 1'b1}; end
        3'd5:    begin w_cmd = k_READ_CMD; w_nack = 1'b1; end
        default: w_cmd = k_STOP_CMD;
      endcase
    end
  end

  assign w_stop_step = r_rw ? 3'd6 : 3'd4;
  assign w_tmo_inc   = r_tmo + 16'd1;

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_err_next   = r_err;
    w_rdata_next = r_rdata;
    w_accept     = 1'b0;
    w_waiting    = 1'b0;
    w_strobe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_step_next  = 3'd0;
          w_err_next   = 2'd0;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.core_ready) begin
          w_strobe     = 1'b1;
          w_state_next = S_WAIT_BUSY;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.core_ready) w_state_next = S_WAIT_DONE;
        else                 w_waiting    = 1'b1;
      end
      S_WAIT_DONE: begin
        if (bus.core_ready) begin
          if (w_cmd == k_WRITE_CMD && bus.core_rx_ack) begin
            w_err_next   = 2'd1;
            w_step_next  = w_stop_step;
            w_state_next = S_ISSUE;
          end else if (w_cmd == k_STOP_CMD) begin
            w_state_next = S_RESP;
          end else begin
            if (w_cmd == k_READ_CMD) w_rdata_next = bus.core_rx_data;
            w_step_next  = r_step + 3'd1;
            w_state_next = S_ISSUE;
          end
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // A stalled handshake abandons the sequence without STOP
    if (w_waiting && w_tmo_inc == TIMEOUT) begin
      w_err_next   = 2'd2;
      w_state_next = S_RESP;
    end
  end

  assign w_tmo_next = (w_state_next != r_state) ? 16'd0 :
                      (w_waiting ? w_tmo_inc : r_tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= 3'd0;
      r_tmo   <= 16'd0;
      r_rw    <= 1'b0;
      r_dev   <= 7'd0;
      r_reg   <= 8'd0;
      r_wdata <= 8'd0;
      r_err   <= 2'd0;
      r_rdata <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_tmo   <= w_tmo_next;
      r_err   <= w_err_next;
      r_rdata <= w_rdata_next;
      if (w_accept) begin
        r_rw    <= bus.req_rw;
        r_dev   <= bus.req_dev;
        r_reg   <= bus.req_reg;
        r_wdata <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.core_write = w_strobe;
  assign bus.core_cmd   = w_strobe ? w_cmd  : 3'd0;
  assign bus.core_data  = w_strobe ? w_data : 8'd0;
  assign bus.core_nack  = w_strobe ? w_nack : 1'b0;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_err    = r_err;
  assign bus.rsp_rdata  = r_rdata;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench: a byte-core responder feeds the sequencer while a list-based
// model of the expected command sequence, result code and read data checks each transaction.
module tb_i2c_reg_sequencer;
  localparam logic [2:0] K_START   = 3'd1;
  localparam logic [2:0] K_RESTART = 3'd2;
  localparam logic [2:0] K_STOP    = 3'd3;
  localparam logic [2:0] K_READ    = 3'd4;
  localparam logic [2:0] K_WRITE   = 3'd5;

  logic clk;
  logic rst_n;
  logic core_ready_drv;
  logic hold_low;

  i2c_reg_sequencer_if bus ();

  i2c_reg_sequencer #(.TIMEOUT(16'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.core_ready = core_ready_drv & ~hold_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] obs_q[$];
  int          g_nack_idx = -1;
  logic [7:0]  g_rx = 8'h00;
  bit          g_stuck = 1'b0;
  int          g_delay = 2;
  logic [7:0]  model_rdata = 8'h00;
  int          txn_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-core responder: records each strobe, goes busy, then completes
  initial begin : responder
    int  wr_cnt;
    bit  is_wr;
    bit  is_rd;
    wr_cnt = 0;
    core_ready_drv   = 1'b1;
    bus.core_rx_ack  = 1'b0;
    bus.core_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.core_write) begin
        obs_q.push_back({bus.core_cmd, bus.core_data, bus.core_nack});
        if (bus.core_cmd == K_START) wr_cnt = 0;
        is_wr = (bus.core_cmd == K_WRITE);
        is_rd = (bus.core_cmd == K_READ);
        @(posedge clk);
        #1;
        if (!g_stuck) core_ready_drv = 1'b0;
        @(negedge clk);
        check("strobe_len", {31'd0, bus.core_write}, 32'd0);
        if (!g_stuck) begin
          repeat (g_delay) @(posedge clk);
          #1;
          // Non-write steps get random ack bits, which must be ignored
          bus.core_rx_ack  = is_wr ? (wr_cnt == g_nack_idx) : 1'($urandom % 2);
          bus.core_rx_data = is_rd ? g_rx : 8'($urandom);
          core_ready_drv   = 1'b1;
        end
        if (is_wr) wr_cnt++;
      end
    end
  end

  task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int nack_idx, input logic [7:0] rxd,
                         input bit stuck, input int hold);
    logic [11:0] full[$];
    logic [11:0] exp_q[$];
    bit          nacked;
    int          wcount, n, cyc, start, got;
    logic [1:0]  exp_err;
    logic [7:0]  exp_rdata;

    // Reference sequence: whole transaction, cut after a NACKed write, then STOP
    if (!rw) full = '{{K_START, 8'h00, 1'b0}, {K_WRITE, dev, 1'b0, 1'b0}, {K_WRITE, rg, 1'b0},
                      {K_WRITE, wd, 1'b0}, {K_STOP, 8'h00, 1'b0}};
    else     full = '{{K_START, 8'h00, 1'b0}, {K_WRITE, dev, 1'b0, 1'b0}, {K_WRITE, rg, 1'b0},
                      {K_RESTART, 8'h00, 1'b0}, {K_WRITE, dev, 1'b1, 1'b0},
                      {K_READ, 8'h00, 1'b1}, {K_STOP, 8'h00, 1'b0}};
    nacked = 1'b0;
    wcount = 0;
    for (int i = 0; i < full.size() - 1; i++) begin
      exp_q.push_back(full[i]);
      if (stuck) break;
      if (full[i][11:9] == K_WRITE) begin
        if (wcount == nack_idx) begin nacked = 1'b1; break; end
        wcount++;
      end
    end
    if (!stuck) exp_q.push_back({K_STOP, 8'h00, 1'b0});
    exp_err   = stuck ? 2'd2 : (nacked ? 2'd1 : 2'd0);
    exp_rdata = (rw && !nacked && !stuck) ? rxd : model_rdata;

    g_nack_idx = nack_idx;
    g_rx       = rxd;
    g_stuck    = stuck;
    g_delay    = int'($urandom_range(1, 4));
    start      = obs_q.size();

    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready", {31'd0, bus.req_ready}, 32'd1);
    if (hold > 0) hold_low = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (hold > 0) begin
      check("hold_no_strobe", {31'd0, bus.core_write}, 32'd0);
      for (int k = 1; k < hold; k++) begin
        @(negedge clk);
        check("hold_no_strobe", {31'd0, bus.core_write}, 32'd0);
      end
      @(posedge clk);
      #1 hold_low = 1'b0;
      @(negedge clk);
      check("first_ready_strobe", {31'd0, bus.core_write}, 32'd1);
    end else begin
      check("latency_n1", {31'd0, bus.core_write}, 32'd1);
    end

    got = 0;
    cyc = 0;
    while (got == 0 && cyc < 3000) begin
      if (bus.rsp_valid) got = 1;
      else begin
        if (!bus.core_write)
          check("idle_zero", {20'd0, bus.core_cmd, bus.core_data, bus.core_nack}, 32'd0);
        @(negedge clk);
        cyc++;
      end
    end
    check("rsp_seen", got, 32'd1);
    if (got != 0) begin
      check("rsp_err", {30'd0, bus.rsp_err}, {30'd0, exp_err});
      check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp_rdata});
      if (stuck) check("timeout_window", ((cyc >= 17 && cyc <= 18) ? 32'd1 : 32'd0), 32'd1);
    end
    check("cmd_count", obs_q.size() - start, exp_q.size());
    for (int i = 0; i < exp_q.size() && start + i < obs_q.size(); i++)
      check($sformatf("cmd%0d", i), {20'd0, obs_q[start + i]}, {20'd0, exp_q[i]});
    @(negedge clk);
    check("rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    model_rdata = exp_rdata;
    g_stuck = 1'b0;
    $display("txn %0d rw=%0d dev=%h reg=%h wd=%h nack_idx=%0d stuck=%0d hold=%0d err=%0d rdata=%h cmds=%0d",
             txn_no, rw, dev, rg, wd, nack_idx, stuck, hold, bus.rsp_err, bus.rsp_rdata,
             obs_q.size() - start);
    txn_no++;
  endtask

  initial begin : main
    int start;
    int n;
    rst_n = 1'b0;
    hold_low = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_dev   = 7'd0;
    bus.req_reg   = 8'd0;
    bus.req_wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_write", {31'd0, bus.core_write}, 32'd0);
    check("rst_core_bus", {20'd0, bus.core_cmd, bus.core_data, bus.core_nack}, 32'd0);
    check("rst_rsp", {21'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 1'b0, 0);
    run_txn(1'b1, 7'h50, 8'h02, 8'h00, -1, 8'h3C, 1'b0, 0);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 0, 8'h00, 1'b0, 0);
    run_txn(1'b1, 7'h50, 8'h02, 8'h00, 2, 8'h77, 1'b0, 0);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 1'b1, 0);
    run_txn(1'b1, 7'h21, 8'h33, 8'h00, -1, 8'h5A, 1'b0, 5);

    for (int t = 0; t < 40; t++) begin
      bit rw_r;
      int nk;
      rw_r = 1'($urandom % 2);
      nk   = ($urandom % 4 == 0) ? int'($urandom_range(0, 2)) : -1;
      run_txn(rw_r, 7'($urandom), 8'($urandom), 8'($urandom), nk, 8'($urandom),
              1'($urandom % 10 == 0), ($urandom % 6 == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    // Make read data nonzero, then reset in WAIT_DONE of step 2
    run_txn(1'b1, 7'h11, 8'h22, 8'h00, -1, 8'hC3, 1'b0, 0);
    g_nack_idx = -1;
    g_stuck    = 1'b0;
    g_delay    = 8;
    start      = obs_q.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_dev   = 7'h50;
    bus.req_reg   = 8'h44;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (obs_q.size() - start < 3 && n < 500) begin @(negedge clk); n++; end
    check("pre_reset_cmds", obs_q.size() - start, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_core_write", {31'd0, bus.core_write}, 32'd0);
    check("mid_rst_core_bus", {20'd0, bus.core_cmd, bus.core_data, bus.core_nack}, 32'd0);
    check("mid_rst_rsp", {21'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_stop_after_rst", obs_q.size() - start, 32'd3);
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    model_rdata = 8'h00;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
